nv_ram_fifo_ctrl_64x128: RTL and testbench

Valid/ready FIFO controller that turns a bare 64-entry × 128-bit two-port RAM (1-cycle registered read address, combinational data out) into a streaming FIFO. It sits directly in front of and behind the RAM macro. It accepts pushes from the upstream producer and drives the RAM write port. It fetches entries through the RAM read port and presents them to the downstream consumer with a valid/ready handshake. The RAM itself stays a separate instance; this block owns pointers, occupancy and the read-fetch pipeline.

---
 rtl/nv_ram_fifo_ctrl_64x128.sv | 94 +++++++++
 tb/tb_nv_ram_fifo_ctrl_64x128.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_fifo_ctrl_64x128.sv
// Valid/ready FIFO controller wrapped around an external 64x128 two-port RAM.
// Owns write/read pointers, occupancy and the one-deep read-fetch pipeline.
module nv_ram_fifo_ctrl_64x128 #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 128,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic             ram_we,
    output logic [AW-1:0]    ram_wa,
    output logic [WIDTH-1:0] ram_di,
    output logic             ram_re,
    output logic [AW-1:0]    ram_ra,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [AW:0]      fifo_count,
    input  logic [31:0]      pwrbus_ram_pd_in,
    output logic [31:0]      pwrbus_ram_pd_out
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          out_vld_q, out_vld_d;

    logic          push;
    logic          pop;
    logic          fetch;
    logic [AW:0]   unfetched;

    assign wr_prdy = (count_q != FULL) & ~rst;
    assign push    = wr_pvld & wr_prdy;
    assign pop     = out_vld_q & rd_prdy;

    // count includes the presented entry, so subtract it to find RAM-only data
    assign unfetched = count_q - {{AW{1'b0}}, out_vld_q};
    assign fetch     = (unfetched != '0) & (~out_vld_q | pop);

    assign ram_we = push;
    assign ram_wa = wr_ptr_q;
    assign ram_di = wr_pd;
    assign ram_re = fetch;
    assign ram_ra = rd_ptr_q;

    assign rd_pvld    = out_vld_q;
    assign rd_pd      = ram_dout;
    assign fifo_count = count_q;

    assign pwrbus_ram_pd_out = pwrbus_ram_pd_in;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        out_vld_d = out_vld_q;
        count_d   = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fetch) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            out_vld_d = 1'b1;
        end else if (pop) begin
            out_vld_d = 1'b0;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_vld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            out_vld_q <= out_vld_d;
        end
    end

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_64x128.sv
// Bench for nv_ram_fifo_ctrl_64x128: behavioural RAM plus a queue model
// that predicts every handshake, RAM port and the presented payload.
module tb_nv_ram_fifo_ctrl_64x128;

    localparam int DEPTH = 64;
    localparam int WIDTH = 128;
    localparam int AW    = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_pvld = 1'b0;
    logic             wr_prdy;
    logic [WIDTH-1:0] wr_pd = '0;
    logic             rd_pvld;
    logic             rd_prdy = 1'b0;
    logic [WIDTH-1:0] rd_pd;
    logic             ram_we;
    logic [AW-1:0]    ram_wa;
    logic [WIDTH-1:0] ram_di;
    logic             ram_re;
    logic [AW-1:0]    ram_ra;
    logic [WIDTH-1:0] ram_dout;
    logic [AW:0]      fifo_count;
    logic [31:0]      pwr_in = 32'h0;
    logic [31:0]      pwr_out;

    always #5 clk = ~clk;

    nv_ram_fifo_ctrl_64x128 dut (
        .clk               (clk),
        .rst               (rst),
        .wr_pvld           (wr_pvld),
        .wr_prdy           (wr_prdy),
        .wr_pd             (wr_pd),
        .rd_pvld           (rd_pvld),
        .rd_prdy           (rd_prdy),
        .rd_pd             (rd_pd),
        .ram_we            (ram_we),
        .ram_wa            (ram_wa),
        .ram_di            (ram_di),
        .ram_re            (ram_re),
        .ram_ra            (ram_ra),
        .ram_dout          (ram_dout),
        .fifo_count        (fifo_count),
        .pwrbus_ram_pd_in  (pwr_in),
        .pwrbus_ram_pd_out (pwr_out)
    );

    // Bare RAM: registered read address, combinational data out
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ra_q = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
    end
    assign ram_dout = mem[ra_q];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Reference model: an entry is presented at max(push+2, prev_pop+1)
    typedef struct {
        logic [WIDTH-1:0] d;
        int               pc;
        int               addr;
    } ent_t;

    ent_t q[$];
    int   cyc      = 0;
    int   last_pop = -100;
    int   n_push   = 0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        q.delete();
        last_pop = -100;
        n_push   = 0;
    endtask

    // One clock cycle: drive, predict, compare, then advance the model
    task automatic cycle(input logic wv, input logic [WIDTH-1:0] d,
                         input logic rr);
        logic e_prdy, e_push, e_vld, e_pop, e_re;
        logic [WIDTH-1:0] e_pd;
        int   e_ra, vc;
        wr_pvld = wv;
        wr_pd   = d;
        rd_prdy = rr;
        #4;
        e_prdy = (q.size() != DEPTH);
        e_push = wv & e_prdy;
        e_vld  = 1'b0;
        e_pd   = '0;
        e_re   = 1'b0;
        e_ra   = 0;
        vc     = 0;
        if (q.size() > 0) begin
            vc = max2(q[0].pc + 2, last_pop + 1);
            e_vld = (cyc >= vc);
            e_pd  = q[0].d;
        end
        e_pop = e_vld & rr;
        if (q.size() > 0 && !e_vld && vc == cyc + 1) begin
            e_re = 1'b1;
            e_ra = q[0].addr;
        end else if (e_pop && q.size() > 1 && q[1].pc <= cyc - 1) begin
            e_re = 1'b1;
            e_ra = q[1].addr;
        end
        check("wr_prdy", WIDTH'(wr_prdy), WIDTH'(e_prdy));
        check("ram_we", WIDTH'(ram_we), WIDTH'(e_push));
        if (e_push) begin
            check("ram_wa", WIDTH'(ram_wa), WIDTH'(n_push % DEPTH));
            check("ram_di", ram_di, d);
        end
        check("rd_pvld", WIDTH'(rd_pvld), WIDTH'(e_vld));
        if (e_vld) check("rd_pd", rd_pd, e_pd);
        check("ram_re", WIDTH'(ram_re), WIDTH'(e_re));
        if (e_re) check("ram_ra", WIDTH'(ram_ra), WIDTH'(e_ra));
        check("fifo_count", WIDTH'(fifo_count), WIDTH'(q.size()));
        @(posedge clk);
        if (e_pop) begin
            void'(q.pop_front());
            last_pop = cyc;
        end
        if (e_push) begin
            q.push_back('{d: d, pc: cyc, addr: n_push % DEPTH});
            n_push++;
        end
        cyc++;
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [WIDTH-1:0] a5;
        a5 = {16{8'hA5}};
        pwr_in = 32'hDEAD_BEEF;
        // Reset with a push attempt held high: it must be blocked
        wr_pvld = 1'b1;
        wr_pd   = a5;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_prdy", WIDTH'(wr_prdy), '0);
        check("rst_ram_we", WIDTH'(ram_we), '0);
        check("rst_rd_pvld", WIDTH'(rd_pvld), '0);
        check("rst_count", WIDTH'(fifo_count), '0);
        check("rst_ram_re", WIDTH'(ram_re), '0);
        check("pwrbus", WIDTH'(pwr_out), WIDTH'(32'hDEAD_BEEF));
        wr_pvld = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        check("post_rst_prdy", WIDTH'(wr_prdy), WIDTH'(1));
        @(posedge clk);
        #1;

        // Single push, 2-cycle latency
        cycle(1'b1, a5, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b1);

        // Fill to full with stalled consumer, then attempt a 65th push
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0);
        repeat (3) cycle(1'b1, WIDTH'(999), 1'b0);
        check("full_count", WIDTH'(fifo_count), WIDTH'(DEPTH));

        // Full with simultaneous pop: refused now, accepted next cycle
        cycle(1'b1, WIDTH'(64), 1'b1);
        check("full_pop_cnt", WIDTH'(fifo_count), WIDTH'(63));
        cycle(1'b1, WIDTH'(64), 1'b1);

        // Drain across the pointer wrap while pushing more
        for (int i = 65; i < 100; i++) cycle(1'b1, WIDTH'(i), 1'b1);
        repeat (70) cycle(1'b0, '0, 1'b1);
        check("drained", WIDTH'(fifo_count), '0);

        // Random backpressure with shifting bias
        for (int i = 0; i < 10000; i++) begin
            int pw, pr;
            pw = (i / 1000) % 2 ? 80 : 40;
            pr = (i / 1000) % 2 ? 30 : 70;
            cycle($urandom_range(99) < pw, rnd128(), $urandom_range(99) < pr);
        end
        repeat (80) cycle(1'b0, '0, 1'b1);

        // Build up 37 entries with the head presented, then reset mid-cycle
        for (int i = 0; i < 37; i++) cycle(1'b1, rnd128(), 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b0);
        check("pre_rst_cnt", WIDTH'(fifo_count), WIDTH'(37));
        check("pre_rst_vld", WIDTH'(rd_pvld), WIDTH'(1));
        #2;
        rst = 1'b1;
        #1;
        check("async_vld", WIDTH'(rd_pvld), '0);
        check("async_cnt", WIDTH'(fifo_count), '0);
        check("async_prdy", WIDTH'(wr_prdy), '0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        cyc += 3;
        #1;
        cycle(1'b1, rnd128(), 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(1), rnd128(), $urandom_range(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
